// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, level counter, programmable almost-full/empty, sticky errors; read latency 1
// (0 with SYNC_FIFO_FWFT_EN). Back-pressure: writes dropped while wr_full, reads ignored while rd_empty.
module sync_fifo_prog #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 4,
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [CNT_WIDTH-1:0]  level,
  input  logic [CNT_WIDTH-1:0]  afull_thresh,
  input  logic [CNT_WIDTH-1:0]  aempty_thresh,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH-1:0]  level_q;
  logic [CNT_WIDTH-1:0]  level_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  afull_q;
  logic                  aempty_q;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  unf_q;
  logic                  unf_d;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    level_d = level_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + CNT_WIDTH'(1);
      2'b01:   level_d = level_q - CNT_WIDTH'(1);
      default: level_d = level_q;
    endcase
  end

  // An error event in the same cycle as clr_err must survive the clear.
  assign ovf_d = (ovf_q & ~clr_err) | (wr_en & full_q);
  assign unf_d = (unf_q & ~clr_err) | (rd_en & empty_q);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      level_q  <= level_d;
      full_q   <= (level_d == DEPTH_C);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= afull_thresh);
      aempty_q <= (level_d <= aempty_thresh);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = ~empty_q;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign wr_full         = full_q;
  assign rd_empty        = empty_q;
  assign wr_almost_full  = afull_q;
  assign rd_almost_empty = aempty_q;
  assign level           = level_q;
  assign overflow        = ovf_q;
  assign underflow       = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;
  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       wr_almost_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic [4:0] level;
  logic [4:0] afull_thresh;
  logic [4:0] aempty_thresh;
  logic       clr_err;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_almost_full(wr_almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty), .level(level),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every word the DUT presents against the queue.
  always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
    if (rstn && rd_valid && rd_en) begin
`else
    if (rstn && rd_valid) begin
`endif
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data_unexpected: got %0h expected no word", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic clear_errs();
    idle(); clr_err = 1'b1; cyc(); clr_err = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
    afull_thresh = 5'd14; aempty_thresh = 5'd2;
    cyc(); cyc();
    chk("rst_empty", 32'(rd_empty), 32'd1);
    chk("rst_aempty", 32'(rd_almost_empty), 32'd1);
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_afull", 32'(wr_almost_full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rd_data", 32'(rd_data), 32'd0);
`endif
    #3 rstn = 1'b1;
    cyc();

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      cyc();
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_afull", 32'(wr_almost_full), (i >= 14) ? 32'd1 : 32'd0);
      chk("fill_aempty", 32'(rd_almost_empty), (i <= 2) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(wr_full), (i == 16) ? 32'd1 : 32'd0);
    end

    // Overflow attempt with 0xAA
    wr_en = 1'b1; wr_data = 8'hAA;
    cyc();
    idle();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    cyc();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_errs();
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain all 16
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1; exp_q.push_back(8'(i));
      cyc();
      chk("drain_level", 32'(level), 32'(16 - i));
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_valid", 32'(rd_valid), 32'd1);
`endif
    end
    idle();
    cyc();
    chk("drain_empty", 32'(rd_empty), 32'd1);
    chk("drain_level0", 32'(level), 32'd0);
    chk("drain_valid_off", 32'(rd_valid), 32'd0);

    // Underflow on empty read
    rd_en = 1'b1;
    cyc();
    idle();
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_valid", 32'(rd_valid), 32'd0);
    chk("unf_level", 32'(level), 32'd0);
    // clr_err together with a fresh underflow: set wins
    rd_en = 1'b1; clr_err = 1'b1;
    cyc();
    idle();
    chk("unf_set_wins", 32'(underflow), 32'd1);
    clear_errs();
    chk("unf_clr", 32'(underflow), 32'd0);

    // Empty with write+read: write accepted, read rejected
    wr_en = 1'b1; wr_data = 8'h30; rd_en = 1'b1;
    cyc();
    idle();
    chk("eboth_level", 32'(level), 32'd1);
    chk("eboth_unf", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("eboth_valid", 32'(rd_valid), 32'd0);
`endif
    rd_en = 1'b1; exp_q.push_back(8'h30);
    cyc();
    idle();
    clear_errs();

    // Steady level 8 with simultaneous traffic across pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      cyc();
    end
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h48 + k); rd_en = 1'b1;
      exp_q.push_back(8'(8'h40 + k));
      cyc();
      chk("steady_level", 32'(level), 32'd8);
    end
    idle();
    for (int k = 12; k < 20; k++) begin
      rd_en = 1'b1; exp_q.push_back(8'(8'h48 + k));
      cyc();
    end
    idle();
    cyc();
    chk("steady_empty", 32'(rd_empty), 32'd1);

    // Full with write+read: read accepted, write dropped
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      cyc();
    end
    wr_en = 1'b1; wr_data = 8'hBB; rd_en = 1'b1; exp_q.push_back(8'h60);
    cyc();
    idle();
    chk("fboth_level", 32'(level), 32'd15);
    chk("fboth_ovf", 32'(overflow), 32'd1);
    chk("fboth_full", 32'(wr_full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1; exp_q.push_back(8'(8'h60 + i));
      cyc();
    end
    idle();
    cyc();
    chk("fboth_empty", 32'(rd_empty), 32'd1);
    clear_errs();

    // Threshold of zero pins almost-full high
    afull_thresh = 5'd0;
    cyc();
    chk("afull_zero", 32'(wr_almost_full), 32'd1);
    afull_thresh = 5'd14;
    cyc();
    chk("afull_restore", 32'(wr_almost_full), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
    wr_en = 1'b1; wr_data = 8'h5A;
    cyc();
    idle();
    chk("fwft_valid", 32'(rd_valid), 32'd1);
    chk("fwft_data", 32'(rd_data), 32'h5A);
    rd_en = 1'b1; exp_q.push_back(8'h5A);
    cyc();
    idle();
    chk("fwft_empty", 32'(rd_empty), 32'd1);
`endif

    cyc(); cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
